// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect FSM and IF/ID pipeline register.
// Stale memory responses in the cycle after a redirect are dropped.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        InstBranch,
    input  logic [15:0] branch_target,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] instD,
    output logic [15:0] pcD,
    output logic        validD,
    output logic [15:0] stall_cnt,
    output logic [15:0] bubble_cnt
);

    typedef enum logic [0:0] {FETCH, REDIRECT} state_t;

    state_t      state, state_next;
    logic [15:0] pc_f, pc_next;
    logic        load_ifid, bubble_ifid;

    assign imem_addr = pc_f;
    assign imem_req  = ~reset;

    always_comb begin
        state_next  = FETCH;
        pc_next     = pc_f;
        load_ifid   = 1'b0;
        bubble_ifid = 1'b0;

        if (InstBranch) begin
            state_next = REDIRECT;
            pc_next    = branch_target;
        end else if (!stallF && state == FETCH && imem_valid) begin
            pc_next = pc_f + 16'd1;
        end

        // Flush beats stall; a held IF/ID neither loads nor bubbles.
        if (flushD) begin
            bubble_ifid = 1'b1;
        end else if (!stallD) begin
            if (state == FETCH && imem_valid && !InstBranch) begin
                load_ifid = 1'b1;
            end else begin
                bubble_ifid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc_f       <= RESET_PC;
            instD      <= NOP_INST;
            pcD        <= 16'h0000;
            validD     <= 1'b0;
            stall_cnt  <= 16'h0000;
            bubble_cnt <= 16'h0000;
        end else begin
            state <= state_next;
            pc_f  <= pc_next;
            if (load_ifid) begin
                instD  <= imem_data;
                pcD    <= pc_f;
                validD <= 1'b1;
            end else if (bubble_ifid) begin
                instD  <= NOP_INST;
                validD <= 1'b0;
            end
            if (stallF && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (bubble_ifid && bubble_cnt != 16'hFFFF) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'hBEEF;

    logic        clk = 1'b0;
    logic        reset, stallF, stallD, flushD, InstBranch, imem_valid;
    logic [15:0] branch_target, imem_data;
    logic        imem_req, validD;
    logic [15:0] imem_addr, instD, pcD, stall_cnt, bubble_cnt;
    logic        w2_req, w2_validD;
    logic [15:0] w2_addr, w2_instD, w2_pcD, w2_stall, w2_bub;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_pc, m_inst, m_pcd, m_stall, m_bub;
    logic        m_valid, m_redir;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .InstBranch(InstBranch), .branch_target(branch_target), .imem_valid(imem_valid),
        .imem_data(imem_data), .imem_req(imem_req), .imem_addr(imem_addr), .instD(instD),
        .pcD(pcD), .validD(validD), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    fetch_stage #(.RESET_PC(16'hFFFF), .NOP_INST(NOP)) dut2 (
        .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .InstBranch(InstBranch), .branch_target(branch_target), .imem_valid(imem_valid),
        .imem_data(imem_data), .imem_req(w2_req), .imem_addr(w2_addr), .instD(w2_instD),
        .pcD(w2_pcD), .validD(w2_validD), .stall_cnt(w2_stall), .bubble_cnt(w2_bub)
    );

    task automatic model_bubble();
        m_inst  = NOP;
        m_valid = 1'b0;
        if (m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
    endtask

    // One clock: advance the model on the rising edge, then settle.
    task automatic step();
        logic fetch_ok;
        @(posedge clk);
        if (reset) begin
            m_pc = 16'h0000; m_redir = 1'b0; m_inst = NOP; m_pcd = 16'h0000;
            m_valid = 1'b0; m_stall = 16'h0000; m_bub = 16'h0000;
        end else begin
            fetch_ok = !m_redir && imem_valid;
            if (flushD) model_bubble();
            else if (!stallD) begin
                if (fetch_ok && !InstBranch) begin
                    m_inst = imem_data; m_pcd = m_pc; m_valid = 1'b1;
                end else model_bubble();
            end
            if (stallF && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (InstBranch) m_pc = branch_target;
            else if (!stallF && fetch_ok) m_pc = m_pc + 16'd1;
            m_redir = InstBranch;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic sf, input logic sd, input logic fl,
                         input logic br, input logic [15:0] tgt);
        imem_valid = v; stallF = sf; stallD = sd; flushD = fl;
        InstBranch = br; branch_target = tgt;
        imem_data = v ? (m_pc ^ 16'hA5A5) : 16'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
        step();
        step();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
    endtask

    task automatic advance_to(input logic [15:0] target);
        for (int i = 0; i < 100 && m_pc != target; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5555);
        step();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req got %b want 0", imem_req);
        end
        checks++;
        if ({imem_addr, instD, pcD, validD, stall_cnt, bubble_cnt} !==
            {16'h0000, NOP, 16'h0000, 1'b0, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state got addr=%h inst=%h pcd=%h v=%b sc=%h bc=%h",
                     imem_addr, instD, pcD, validD, stall_cnt, bubble_cnt);
        end
        checks++;
        if (w2_addr !== 16'hFFFF) begin
            errors++; $display("FAIL reset_pc_param got %h want ffff", w2_addr);
        end
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL first_fetch got req=%b addr=%h want 1/0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_straight();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            step();
            checks++;
            if ({pcD, validD, instD, imem_addr, bubble_cnt} !==
                {16'(i), 1'b1, 16'(i) ^ 16'hA5A5, 16'(i + 1), 16'h0000}) begin
                errors++;
                $display("FAIL straight[%0d] got pcd=%h v=%b inst=%h addr=%h bc=%h",
                         i, pcD, validD, instD, imem_addr, bubble_cnt);
            end
        end
    endtask

    task automatic test_load_use();
        logic [15:0] held_inst, held_pc;
        do_reset();
        advance_to(16'h0005);
        held_inst = m_inst; held_pc = m_pcd;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
            step();
        end
        checks++;
        if ({imem_addr, instD, pcD, stall_cnt} !== {16'h0005, held_inst, held_pc, 16'd2}) begin
            errors++;
            $display("FAIL load_use_hold got addr=%h inst=%h pcd=%h sc=%h want 0005/%h/%h/0002",
                     imem_addr, instD, pcD, stall_cnt, held_inst, held_pc);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        checks++;
        if ({imem_addr, pcD, validD} !== {16'h0006, 16'h0005, 1'b1}) begin
            errors++;
            $display("FAIL load_use_resume got addr=%h pcd=%h v=%b want 0006/0005/1",
                     imem_addr, pcD, validD);
        end
    endtask

    task automatic test_branch();
        do_reset();
        advance_to(16'h0009);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0040);
        step();
        checks++;
        if ({imem_addr, validD} !== {16'h0040, 1'b0}) begin
            errors++; $display("FAIL branch_redirect got addr=%h v=%b want 0040/0", imem_addr, validD);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        imem_data = 16'hDEAD;
        step();
        checks++;
        if ({imem_addr, validD, instD} !== {16'h0040, 1'b0, NOP}) begin
            errors++;
            $display("FAIL branch_stale got addr=%h v=%b inst=%h want 0040/0/%h",
                     imem_addr, validD, instD, NOP);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        checks++;
        if ({instD, pcD, validD, imem_addr} !== {16'h0040 ^ 16'hA5A5, 16'h0040, 1'b1, 16'h0041}) begin
            errors++;
            $display("FAIL branch_target_load got inst=%h pcd=%h v=%b addr=%h",
                     instD, pcD, validD, imem_addr);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        advance_to(16'h0003);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            step();
        end
        checks++;
        if ({imem_addr, validD, instD, bubble_cnt} !== {16'h0003, 1'b0, NOP, 16'd3}) begin
            errors++;
            $display("FAIL mem_wait got addr=%h v=%b inst=%h bc=%h want 0003/0/%h/0003",
                     imem_addr, validD, instD, bubble_cnt, NOP);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        checks++;
        if ({w2_addr, w2_pcD, w2_validD} !== {16'h0000, 16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL pc_wrap got addr=%h pcd=%h v=%b want 0000/ffff/1",
                     w2_addr, w2_pcD, w2_validD);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0),
                  1'($urandom_range(0, 7) == 0), 16'($urandom));
            if (imem_valid && $urandom_range(0, 1) == 1) imem_data = 16'($urandom);
            step();
            checks++;
            if ({imem_req, imem_addr, instD, pcD, validD, stall_cnt, bubble_cnt} !==
                {~reset, m_pc, m_inst, m_pcd, m_valid, m_stall, m_bub}) begin
                errors++;
                $display("FAIL random[%0d] got req=%b addr=%h inst=%h pcd=%h v=%b sc=%h bc=%h want %b %h %h %h %b %h %h",
                         i, imem_req, imem_addr, instD, pcD, validD, stall_cnt, bubble_cnt,
                         ~reset, m_pc, m_inst, m_pcd, m_valid, m_stall, m_bub);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
            step();
        end
        checks++;
        if ({stall_cnt, m_stall, imem_addr} !== {16'hFFFF, 16'hFFFF, 16'h0000}) begin
            errors++;
            $display("FAIL stall_saturate got sc=%h addr=%h want ffff/0000", stall_cnt, imem_addr);
        end
    endtask

    initial begin
        reset = 1'b1;
        m_pc = 16'h0000; m_redir = 1'b0; m_inst = NOP; m_pcd = 16'h0000;
        m_valid = 1'b0; m_stall = 16'h0000; m_bub = 16'h0000;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        test_reset();
        test_straight();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_wrap();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
